race_state_ctrl: RTL and testbench
==================================

Name: race_state_ctrl

Overview:
- Parametrised top-level game-flow controller for the racing game: sequences lobby, settings, countdown, race, pause and finish.
- Adds a configurable countdown length, a simulation-scalable tick, N players, first/all finish modes, a race timer and winner capture.
- Sits between the button front-end (debounce + one-pulse, external to this block) and the render/physics blocks, which consume `state`, `countdown_val`, `race_time` and `winner`.

Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per tick (1 s at 100 MHz); must be ≥2.
- COUNTDOWN_SEC, 3: countdown start value in ticks; must be ≥1.
- CNT_W, 4: width of `countdown_val`; must hold COUNTDOWN_SEC.
- NUM_PLAYERS, 2: number of `player_done` inputs; must be ≥1.
- FINISH_ALL, 0: 0 = race ends on first player done; 1 = race ends when all players are done.
- TIME_W, 16: width of `race_time`, in ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_p  in  1  start button, one-cycle pulse
- setting_p  in  1  setting button, one-cycle pulse
- pause_p  in  1  pause button, one-cycle pulse
- player_done  in  NUM_PLAYERS  per-player finish-line crossing; level or pulse
- state  out  3  IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
- countdown_val  out  CNT_W  remaining countdown ticks
- race_time  out  TIME_W  elapsed race ticks
- winner  out  NUM_PLAYERS  one-hot (multi-hot on tie) first finisher(s)
- state_chg  out  1  one-cycle pulse while `state` differs from its previous-cycle value

Behaviour:
- **Registered outputs:** all outputs are registered; every transition takes effect on the clk edge after the causing input.
- **Reset:**
  - state=IDLE, countdown_val=COUNTDOWN_SEC, race_time=0, winner=0, state_chg=0.
  - Internal tick_cnt=0, done_mask=0, resume_state=RACING.
  - Reset mid-race aborts immediately to these values.
- **Tick counter:**
  - tick_cnt counts 0..TICK_CYCLES-1 in COUNTDOWN and RACING; tick = (tick_cnt==TICK_CYCLES-1), then wraps to 0.
  - Held in PAUSE.
  - Cleared in IDLE, SETTING, FINISH and on COUNTDOWN entry.
- **IDLE:**
  - start_p → COUNTDOWN; countdown_val=COUNTDOWN_SEC, race_time=0, winner=0, done_mask=0.
  - Otherwise setting_p → SETTING.
  - start_p has priority on simultaneous presses.
- **SETTING:** setting_p → IDLE. Other inputs are ignored.
- **COUNTDOWN:**
  - On tick: if countdown_val==1 → RACING with countdown_val=0; else countdown_val decrements.
  - Duration is exactly COUNTDOWN_SEC×TICK_CYCLES cycles.
  - pause_p → PAUSE with resume_state=COUNTDOWN; the countdown freezes.
  - If pause_p and the final tick coincide, the pause wins and the tick is dropped.
- **RACING:**
  - done_mask |= player_done every cycle.
  - On the first cycle where the new done_mask≠0, winner latches that cycle's new bits; ties give multi-hot.
  - race_time increments on each tick and saturates at 2^TIME_W-1.
  - Finish condition: new done_mask≠0 (FINISH_ALL=0) or new done_mask all ones (FINISH_ALL=1) → FINISH.
  - The finish condition takes priority over a simultaneous pause_p.
  - Otherwise pause_p → PAUSE with resume_state=RACING.
- **PAUSE:**
  - pause_p → resume_state.
  - player_done is ignored; race_time, countdown_val and tick_cnt are frozen.
  - start_p and setting_p are ignored.
- **FINISH:**
  - race_time and winner hold.
  - start_p → IDLE, clearing race_time, winner and done_mask, and setting countdown_val=COUNTDOWN_SEC.
- **countdown_val by state:** COUNTDOWN_SEC in IDLE/SETTING; 0 in RACING/FINISH; frozen value in PAUSE.
- **Unused encodings:** 2 and 7 recover to IDLE on the next edge.

Optional Feature:
- Macro name: PAUSE_TIMEOUT_EN.
- Defined: adds parameter PAUSE_TIMEOUT (default 30, in ticks).
  - Within PAUSE a separate counter counts cycles; after PAUSE_TIMEOUT×TICK_CYCLES cycles without pause_p, state → IDLE with the IDLE-entry clears.
  - The counter restarts on every PAUSE entry.
  - pause_p on the expiry cycle resumes instead of timing out.
- Undefined: PAUSE persists indefinitely and no extra logic is built.

Test Plan (TICK_CYCLES=10, COUNTDOWN_SEC=3, NUM_PLAYERS=2, TIME_W=8):
- Reset, then start_p at cycle 0 → state=3 at cycle 1; countdown_val 3→2→1 at cycles 11 and 21; state=4 with countdown_val=0 at cycle 31; state_chg pulses at cycles 2 and 32.
- In IDLE, setting_p → 1; setting_p again → 0; start_p and setting_p together in IDLE → 3.
- Pause at countdown_val=2 mid-tick, hold 50 cycles, resume → remaining countdown cycles match the unpaused total; countdown_val stays 2 throughout PAUSE.
- FINISH_ALL=0: player_done=2'b10 after 25 ticks of racing → state=6, winner=2'b10, race_time=25; player_done=2'b11 on the same cycle as pause_p → state=6, winner=2'b11.
- FINISH_ALL=1: player_done=01, later 10 → FINISH only after the second, winner=01; race past 255 ticks → race_time saturates at 255.
- PAUSE_TIMEOUT_EN with PAUSE_TIMEOUT=2 → state=0 exactly 20 cycles after PAUSE entry; rst asserted mid-RACING → all reset values on the next edge.

Source files
------------

// File: rtl/race_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : race_state_ctrl
// Brief    : Game-flow controller: lobby, settings, countdown, race, pause and
//            finish, with race timer and winner capture. Optional pause
//            timeout is enabled by defining PAUSE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module race_state_ctrl #(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int CNT_W         = 4,
    parameter int NUM_PLAYERS   = 2,
    parameter int FINISH_ALL    = 0,
    parameter int TIME_W        = 16
`ifdef PAUSE_TIMEOUT_EN
    ,
    parameter int PAUSE_TIMEOUT = 30
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_p,
    input  logic                   setting_p,
    input  logic                   pause_p,
    input  logic [NUM_PLAYERS-1:0] player_done,
    output logic [2:0]             state,
    output logic [CNT_W-1:0]       countdown_val,
    output logic [TIME_W-1:0]      race_time,
    output logic [NUM_PLAYERS-1:0] winner,
    output logic                   state_chg
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SETTING   = 3'd1;
    localparam logic [2:0] c_COUNTDOWN = 3'd3;
    localparam logic [2:0] c_RACING    = 3'd4;
    localparam logic [2:0] c_PAUSE     = 3'd5;
    localparam logic [2:0] c_FINISH    = 3'd6;

    localparam int               c_TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CD_START  = CNT_W'(COUNTDOWN_SEC);

    logic [2:0]             r_state, w_state_nxt;
    logic [2:0]             r_prev_state;
    logic                   r_state_chg;
    logic [2:0]             r_resume, w_resume_nxt;
    logic [c_TICK_W-1:0]    r_tick_cnt, w_tick_nxt, w_tick_inc;
    logic [CNT_W-1:0]       r_cd, w_cd_nxt;
    logic [TIME_W-1:0]      r_race_time, w_time_nxt;
    logic [NUM_PLAYERS-1:0] r_winner, w_winner_nxt;
    logic [NUM_PLAYERS-1:0] r_done_mask, w_mask_nxt, w_done_new;
    logic                   w_tick, w_finish, w_pt_expire;

    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;
        w_tick_nxt   = r_tick_cnt;
        w_cd_nxt     = r_cd;
        w_time_nxt   = r_race_time;
        w_winner_nxt = r_winner;
        w_mask_nxt   = r_done_mask;
        w_done_new   = r_done_mask | player_done;
        w_finish     = (FINISH_ALL != 0) ? (&w_done_new) : (|w_done_new);
        w_tick       = (r_tick_cnt == c_TICK_LAST);
        w_tick_inc   = w_tick ? '0 : r_tick_cnt + 1'b1;

        case (r_state)
            c_IDLE: begin
                w_tick_nxt = '0;
                if (start_p) begin
                    w_state_nxt  = c_COUNTDOWN;
                    w_cd_nxt     = c_CD_START;
                    w_time_nxt   = '0;
                    w_winner_nxt = '0;
                    w_mask_nxt   = '0;
                end else if (setting_p) begin
                    w_state_nxt = c_SETTING;
                end
            end
            c_SETTING: begin
                w_tick_nxt = '0;
                if (setting_p) w_state_nxt = c_IDLE;
            end
            c_COUNTDOWN: begin
                // An accepted pause drops any coincident tick and holds tick_cnt
                if (pause_p) begin
                    w_state_nxt  = c_PAUSE;
                    w_resume_nxt = c_COUNTDOWN;
                end else begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick) begin
                        if (r_cd == CNT_W'(1)) begin
                            w_state_nxt = c_RACING;
                            w_cd_nxt    = '0;
                        end else begin
                            w_cd_nxt = r_cd - 1'b1;
                        end
                    end
                end
            end
            c_RACING: begin
                w_mask_nxt = w_done_new;
                if ((r_done_mask == '0) && (w_done_new != '0)) w_winner_nxt = player_done;
                if (!w_finish && pause_p) begin
                    w_state_nxt  = c_PAUSE;
                    w_resume_nxt = c_RACING;
                end else begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick && (r_race_time != {TIME_W{1'b1}})) w_time_nxt = r_race_time + 1'b1;
                    if (w_finish) w_state_nxt = c_FINISH;
                end
            end
            c_PAUSE: begin
                if (pause_p) w_state_nxt = r_resume;
                else if (w_pt_expire) w_state_nxt = c_IDLE;
            end
            c_FINISH: begin
                w_tick_nxt = '0;
                if (start_p) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase

        // Every path into the lobby (finish, timeout, bad encoding) gets the same clean slate
        if ((w_state_nxt == c_IDLE) || (w_state_nxt == c_SETTING)) begin
            w_cd_nxt     = c_CD_START;
            w_time_nxt   = '0;
            w_winner_nxt = '0;
            w_mask_nxt   = '0;
            w_tick_nxt   = '0;
        end
    end

`ifdef PAUSE_TIMEOUT_EN
    localparam longint c_PT_LIMIT = longint'(PAUSE_TIMEOUT) * longint'(TICK_CYCLES);
    localparam int     c_PT_W     = (c_PT_LIMIT > 1) ? $clog2(c_PT_LIMIT) : 1;

    logic [c_PT_W-1:0] r_pause_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != c_PAUSE)) r_pause_cnt <= '0;
        else                             r_pause_cnt <= r_pause_cnt + 1'b1;
    end

    assign w_pt_expire = (r_state == c_PAUSE) && (r_pause_cnt == c_PT_W'(c_PT_LIMIT - 1));
`else
    assign w_pt_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_prev_state <= c_IDLE;
            r_state_chg  <= 1'b0;
            r_resume     <= c_RACING;
            r_tick_cnt   <= '0;
            r_cd         <= c_CD_START;
            r_race_time  <= '0;
            r_winner     <= '0;
            r_done_mask  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_state <= r_state;
            r_state_chg  <= (r_state != r_prev_state);
            r_resume     <= w_resume_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_cd         <= w_cd_nxt;
            r_race_time  <= w_time_nxt;
            r_winner     <= w_winner_nxt;
            r_done_mask  <= w_mask_nxt;
        end
    end

    assign state         = r_state;
    assign countdown_val = r_cd;
    assign race_time     = r_race_time;
    assign winner        = r_winner;
    assign state_chg     = r_state_chg;

endmodule
`default_nettype wire

// File: tb/tb_race_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_race_state_ctrl
// Brief    : Bench for race_state_ctrl; first-finish and all-finish instances
//            share stimulus and are compared against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_race_state_ctrl;

    localparam int c_TICKS = 10;
    localparam int c_SEC   = 3;
`ifdef PAUSE_TIMEOUT_EN
    localparam int c_PT_CYC = 2 * c_TICKS;
    localparam int c_HOLD   = 15;
`else
    localparam int c_HOLD   = 50;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0, start_p = 1'b0, setting_p = 1'b0, pause_p = 1'b0;
    logic [1:0] player_done = 2'b00;

    logic [2:0] st_a, st_b;
    logic [3:0] cd_a, cd_b;
    logic [7:0] rt_a, rt_b;
    logic [1:0] win_a, win_b;
    logic       chg_a, chg_b;

    int n_chk = 0;
    int n_err = 0;

    // model: progress is tracked as counts of active cycles rather than tick counters
    int m_st[2], m_prev[2], m_chg[2], m_cde[2], m_rc[2], m_mask[2], m_win[2], m_res[2], m_pc[2];

    always #5 clk = ~clk;

    race_state_ctrl #(
        .TICK_CYCLES(c_TICKS), .COUNTDOWN_SEC(c_SEC), .CNT_W(4), .NUM_PLAYERS(2),
        .FINISH_ALL(0), .TIME_W(8)
`ifdef PAUSE_TIMEOUT_EN
        , .PAUSE_TIMEOUT(2)
`endif
    ) u_any (
        .clk(clk), .rst(rst), .start_p(start_p), .setting_p(setting_p), .pause_p(pause_p),
        .player_done(player_done), .state(st_a), .countdown_val(cd_a), .race_time(rt_a),
        .winner(win_a), .state_chg(chg_a)
    );

    race_state_ctrl #(
        .TICK_CYCLES(c_TICKS), .COUNTDOWN_SEC(c_SEC), .CNT_W(4), .NUM_PLAYERS(2),
        .FINISH_ALL(1), .TIME_W(8)
`ifdef PAUSE_TIMEOUT_EN
        , .PAUSE_TIMEOUT(2)
`endif
    ) u_all (
        .clk(clk), .rst(rst), .start_p(start_p), .setting_p(setting_p), .pause_p(pause_p),
        .player_done(player_done), .state(st_b), .countdown_val(cd_b), .race_time(rt_b),
        .winner(win_b), .state_chg(chg_b)
    );

    function automatic void model_clear(int m);
        m_cde[m] = 0; m_rc[m] = 0; m_mask[m] = 0; m_win[m] = 0;
    endfunction

    function automatic void model_step(int m, logic r, logic s, logic t, logic p, logic [1:0] pd);
        int chg_n, nm;
        bit fin;
        if (r) begin
            m_st[m] = 0; m_prev[m] = 0; m_chg[m] = 0; m_res[m] = 4; m_pc[m] = 0;
            model_clear(m);
            return;
        end
        chg_n = (m_st[m] != m_prev[m]) ? 1 : 0;
        m_prev[m] = m_st[m];
        case (m_st[m])
            0: if (s) begin m_st[m] = 3; model_clear(m); end
               else if (t) m_st[m] = 1;
            1: if (t) m_st[m] = 0;
            3: if (p) begin m_st[m] = 5; m_res[m] = 3; m_pc[m] = 0; end
               else begin
                   m_cde[m]++;
                   if (m_cde[m] == c_SEC * c_TICKS) m_st[m] = 4;
               end
            4: begin
                nm  = m_mask[m] | int'(pd);
                if (m_mask[m] == 0 && nm != 0) m_win[m] = int'(pd);
                fin = (m == 1) ? (nm == 3) : (nm != 0);
                m_mask[m] = nm;
                if (!fin && p) begin m_st[m] = 5; m_res[m] = 4; m_pc[m] = 0; end
                else begin
                    m_rc[m]++;
                    if (fin) m_st[m] = 6;
                end
            end
            5: if (p) m_st[m] = m_res[m];
               else begin
`ifdef PAUSE_TIMEOUT_EN
                   m_pc[m]++;
                   if (m_pc[m] == c_PT_CYC) begin m_st[m] = 0; model_clear(m); end
`endif
               end
            6: if (s) begin m_st[m] = 0; model_clear(m); end
            default: m_st[m] = 0;
        endcase
        m_chg[m] = chg_n;
    endfunction

    function automatic int exp_cd(int m);
        case (m_st[m])
            0, 1:    return c_SEC;
            3:       return c_SEC - m_cde[m] / c_TICKS;
            5:       return (m_res[m] == 3) ? c_SEC - m_cde[m] / c_TICKS : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_rt(int m);
        return (m_rc[m] / c_TICKS > 255) ? 255 : m_rc[m] / c_TICKS;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mode(int m, logic [2:0] st, logic [3:0] cd, logic [7:0] rt,
                            logic [1:0] w, logic c);
        chk($sformatf("m%0d_state", m),     32'(st), 32'(m_st[m]));
        chk($sformatf("m%0d_countdown", m), 32'(cd), 32'(exp_cd(m)));
        chk($sformatf("m%0d_race_time", m), 32'(rt), 32'(exp_rt(m)));
        chk($sformatf("m%0d_winner", m),    32'(w),  32'(m_win[m]));
        chk($sformatf("m%0d_state_chg", m), 32'(c),  32'(m_chg[m]));
    endtask

    task automatic step(logic r, logic s, logic t, logic p, logic [1:0] pd);
        rst = r; start_p = s; setting_p = t; pause_p = p; player_done = pd;
        @(posedge clk);
        model_step(0, r, s, t, p, pd);
        model_step(1, r, s, t, p, pd);
        @(negedge clk);
        rst = 1'b0; start_p = 1'b0; setting_p = 1'b0; pause_p = 1'b0; player_done = 2'b00;
        chk_mode(0, st_a, cd_a, rt_a, win_a, chg_a);
        chk_mode(1, st_b, cd_b, rt_b, win_b, chg_b);
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        int         n;
        logic       r, s, t, p;
        logic [1:0] pd;

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("reset_state", 32'(st_a), 32'd0);
        chk("reset_cd", 32'(cd_a), 32'd3);

        // lobby navigation and simultaneous start/setting
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("idle_to_setting", 32'(st_a), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("setting_to_idle", 32'(st_a), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("start_priority", 32'(st_a), 32'd3);

        // pause in countdown at value 2, mid-tick
        idle_steps(15);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("cd_pause_entry", 32'(st_a), 32'd5);
        for (int i = 0; i < c_HOLD; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            chk("cd_frozen_any", 32'(cd_a), 32'd2);
            chk("cd_frozen_all", 32'(cd_b), 32'd2);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("cd_resume", 32'(st_a), 32'd3);
        n = 0;
        while (st_a != 3'd4 && n < 40) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            n++;
        end
        chk("cd_remaining_cycles", 32'(n), 32'd15);

        // first-finish vs all-finish
        idle_steps(250);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("any_finish_state", 32'(st_a), 32'd6);
        chk("any_finish_winner", 32'(win_a), 32'd2);
        chk("any_finish_time", 32'(rt_a), 32'd25);
        chk("all_still_racing", 32'(st_b), 32'd4);
        idle_steps(20);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("all_finish_state", 32'(st_b), 32'd6);
        chk("all_finish_winner", 32'(win_b), 32'd2);

        // tie with simultaneous pause
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("finish_to_idle", 32'(st_a), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        idle_steps(30);
        chk("racing_again", 32'(st_b), 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("tie_state_any", 32'(st_a), 32'd6);
        chk("tie_winner_any", 32'(win_a), 32'd3);
        chk("tie_winner_all", 32'(win_b), 32'd3);

        // race timer saturation
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        idle_steps(30 + 2600);
        chk("time_sat_any", 32'(rt_a), 32'd255);
        chk("time_sat_all", 32'(rt_b), 32'd255);

        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("race_pause", 32'(st_a), 32'd5);
`ifdef PAUSE_TIMEOUT_EN
        for (int i = 0; i < c_PT_CYC - 1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            chk("pause_held", 32'(st_a), 32'd5);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("pause_timeout", 32'(st_a), 32'd0);
`else
        idle_steps(100);
        chk("pause_persists", 32'(st_a), 32'd5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        chk("race_resume", 32'(st_a), 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
`endif

        // reset mid-race
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        idle_steps(45);
        chk("pre_reset_time", 32'(rt_a), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_cd", 32'(cd_a), 32'd3);
        chk("rst_time", 32'(rt_a), 32'd0);
        chk("rst_winner", 32'(win_a), 32'd0);
        chk("rst_chg", 32'(chg_a), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            s  = ($urandom_range(0, 19) == 0);
            t  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 29) == 0);
            pd = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(r, s, t, p, pd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
